// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer: id/data/register widths
// and the per-entry record.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_W     = 5;

    typedef logic [ROB_W-1:0] rob_type_t;
    typedef logic [31:0]      data_type_t;
    typedef logic [31:0]      addr_type_t;
    typedef logic [4:0]       reg_type_t;

    localparam rob_type_t ROB_RESET = '0;
    localparam logic      TRUE      = 1'b1;
    localparam logic      FALSE     = 1'b0;

    typedef struct packed {
        logic       busy;
        logic       ready;
        reg_type_t  rd;
        data_type_t value;
        logic       is_load;
        logic       is_store;
        logic       is_jump;
        logic       pred;
        logic       real_jump;
        addr_type_t inst_pos;
        addr_type_t rb_pos;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of dispatcher, CDB, commit and debug signals around the reorder buffer.
// master = surrounding core (dispatcher, ALU, LSU, regfile), slave = the ROB.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic       enable_from_dispatcher;
    reg_type_t  rd_from_dispatcher;
    logic       is_load_from_dispatcher;
    logic       is_store_from_dispatcher;
    logic       is_jump_from_dispatcher;
    logic       if_jump_predicted_from_dispatcher;
    addr_type_t inst_pos_from_dispatcher;
    addr_type_t roll_back_pos_from_dispatcher;
    rob_type_t  rob_id_to_dispatcher;
    logic       full_to_dispatcher;

    rob_type_t  Q1_from_dispatcher;
    rob_type_t  Q2_from_dispatcher;
    logic       if_Q1_rdy_to_dispatcher;
    logic       if_Q2_rdy_to_dispatcher;
    data_type_t data1_to_dispatcher;
    data_type_t data2_to_dispatcher;

    logic       enable_from_alu;
    rob_type_t  rob_id_from_rs;
    data_type_t result_from_alu;
    logic       jump_flag_from_alu;
    logic       enable_from_lsu;
    rob_type_t  rob_id_from_lsb;
    data_type_t result_from_lsu;

    rob_type_t  head_rob_id_to_lsb;
    logic       store_commit_to_lsb;
    logic       enable_to_register;
    reg_type_t  reg_id_to_register;
    rob_type_t  rob_id_to_register;
    data_type_t data_to_register;
    logic       rollback_flag;
    addr_type_t rollback_pos_to_fetcher;

    rob_type_t  dbg_head;
    rob_type_t  dbg_tail;
    rob_type_t  dbg_count;

    modport master (
        output enable_from_dispatcher, rd_from_dispatcher, is_load_from_dispatcher,
               is_store_from_dispatcher, is_jump_from_dispatcher,
               if_jump_predicted_from_dispatcher, inst_pos_from_dispatcher,
               roll_back_pos_from_dispatcher, Q1_from_dispatcher, Q2_from_dispatcher,
               enable_from_alu, rob_id_from_rs, result_from_alu, jump_flag_from_alu,
               enable_from_lsu, rob_id_from_lsb, result_from_lsu,
        input  rob_id_to_dispatcher, full_to_dispatcher, if_Q1_rdy_to_dispatcher,
               if_Q2_rdy_to_dispatcher, data1_to_dispatcher, data2_to_dispatcher,
               head_rob_id_to_lsb, store_commit_to_lsb, enable_to_register,
               reg_id_to_register, rob_id_to_register, data_to_register,
               rollback_flag, rollback_pos_to_fetcher, dbg_head, dbg_tail, dbg_count
    );

    modport slave (
        input  enable_from_dispatcher, rd_from_dispatcher, is_load_from_dispatcher,
               is_store_from_dispatcher, is_jump_from_dispatcher,
               if_jump_predicted_from_dispatcher, inst_pos_from_dispatcher,
               roll_back_pos_from_dispatcher, Q1_from_dispatcher, Q2_from_dispatcher,
               enable_from_alu, rob_id_from_rs, result_from_alu, jump_flag_from_alu,
               enable_from_lsu, rob_id_from_lsb, result_from_lsu,
        output rob_id_to_dispatcher, full_to_dispatcher, if_Q1_rdy_to_dispatcher,
               if_Q2_rdy_to_dispatcher, data1_to_dispatcher, data2_to_dispatcher,
               head_rob_id_to_lsb, store_commit_to_lsb, enable_to_register,
               reg_id_to_register, rob_id_to_register, data_to_register,
               rollback_flag, rollback_pos_to_fetcher, dbg_head, dbg_tail, dbg_count
    );

endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order commit buffer: allocates ids, captures CDB results, retires one
// entry per cycle and flushes the whole core on a mispredicted jump at commit.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    reorder_buffer_if.slave rob_if
);

    // Slot 0 is never allocated: id 0 means "no producer".
    rob_entry_t rob_q [DEPTH+1];
    rob_entry_t rob_d [DEPTH+1];

    rob_type_t  head_q, head_d;
    rob_type_t  tail_q, tail_d;
    rob_type_t  count_q, count_d;

    logic       reg_en_q, reg_en_d;
    reg_type_t  reg_id_q, reg_id_d;
    rob_type_t  reg_rob_q, reg_rob_d;
    data_type_t reg_data_q, reg_data_d;
    logic       store_commit_q, store_commit_d;
    logic       rollback_q, rollback_d;
    addr_type_t rollback_pos_q, rollback_pos_d;

    rob_entry_t head_e;
    logic       alu_hit, lsu_hit, alloc_ok, commit_ok, mispredict;

    function automatic rob_type_t ptr_inc(input rob_type_t p);
        return (p == rob_type_t'(DEPTH)) ? rob_type_t'(1) : p + rob_type_t'(1);
    endfunction

    function automatic logic id_valid(input rob_type_t id);
        return (id != ROB_RESET) && (id <= rob_type_t'(DEPTH));
    endfunction

    assign head_e     = rob_q[head_q];
    assign alu_hit    = rob_if.enable_from_alu && id_valid(rob_if.rob_id_from_rs)
                        && rob_q[rob_if.rob_id_from_rs].busy;
    assign lsu_hit    = rob_if.enable_from_lsu && id_valid(rob_if.rob_id_from_lsb)
                        && rob_q[rob_if.rob_id_from_lsb].busy;
    assign alloc_ok   = rob_if.enable_from_dispatcher && (count_q != rob_type_t'(DEPTH));
    assign commit_ok  = (count_q != '0) && head_e.ready;
    assign mispredict = commit_ok && head_e.is_jump && (head_e.pred != head_e.real_jump);

    always_comb begin
        rob_d          = rob_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        reg_en_d       = FALSE;
        store_commit_d = FALSE;
        rollback_d     = FALSE;
        reg_id_d       = reg_id_q;
        reg_rob_d      = reg_rob_q;
        reg_data_d     = reg_data_q;
        rollback_pos_d = rollback_pos_q;
        if (rdy_in) begin
            if (alu_hit) begin
                rob_d[rob_if.rob_id_from_rs].ready     = TRUE;
                rob_d[rob_if.rob_id_from_rs].value     = rob_if.result_from_alu;
                rob_d[rob_if.rob_id_from_rs].real_jump = rob_if.jump_flag_from_alu;
            end
            if (lsu_hit) begin
                rob_d[rob_if.rob_id_from_lsb].ready = TRUE;
                if (!rob_q[rob_if.rob_id_from_lsb].is_store)
                    rob_d[rob_if.rob_id_from_lsb].value = rob_if.result_from_lsu;
            end
            if (alloc_ok) begin
                rob_d[tail_q] = '{busy: TRUE, ready: FALSE,
                                  rd: rob_if.rd_from_dispatcher, value: '0,
                                  is_load: rob_if.is_load_from_dispatcher,
                                  is_store: rob_if.is_store_from_dispatcher,
                                  is_jump: rob_if.is_jump_from_dispatcher,
                                  pred: rob_if.if_jump_predicted_from_dispatcher,
                                  real_jump: FALSE,
                                  inst_pos: rob_if.inst_pos_from_dispatcher,
                                  rb_pos: rob_if.roll_back_pos_from_dispatcher};
                tail_d = ptr_inc(tail_q);
            end
            if (commit_ok) begin
                rob_d[head_q].busy = FALSE;
                head_d             = ptr_inc(head_q);
                if ((head_e.rd != '0) && !head_e.is_store) begin
                    reg_en_d   = TRUE;
                    reg_id_d   = head_e.rd;
                    reg_rob_d  = head_q;
                    reg_data_d = head_e.value;
                end
                if (head_e.is_store) store_commit_d = TRUE;
            end
            count_d = count_q + rob_type_t'(alloc_ok) - rob_type_t'(commit_ok);
            // The mispredicting jump's own register write above still goes out.
            if (mispredict) begin
                rollback_d     = TRUE;
                rollback_pos_d = head_e.rb_pos;
                for (int i = 0; i <= DEPTH; i++) rob_d[i].busy = FALSE;
                head_d  = rob_type_t'(1);
                tail_d  = rob_type_t'(1);
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rob_q          <= '{default: '0};
            head_q         <= rob_type_t'(1);
            tail_q         <= rob_type_t'(1);
            count_q        <= '0;
            reg_en_q       <= FALSE;
            reg_id_q       <= '0;
            reg_rob_q      <= '0;
            reg_data_q     <= '0;
            store_commit_q <= FALSE;
            rollback_q     <= FALSE;
            rollback_pos_q <= '0;
        end else begin
            rob_q          <= rob_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            reg_en_q       <= reg_en_d;
            reg_id_q       <= reg_id_d;
            reg_rob_q      <= reg_rob_d;
            reg_data_q     <= reg_data_d;
            store_commit_q <= store_commit_d;
            rollback_q     <= rollback_d;
            rollback_pos_q <= rollback_pos_d;
        end
    end

    assign rob_if.rob_id_to_dispatcher    = tail_q;
    assign rob_if.full_to_dispatcher      = (count_q >= rob_type_t'(DEPTH - 1));
    assign rob_if.if_Q1_rdy_to_dispatcher = id_valid(rob_if.Q1_from_dispatcher)
                                            && rob_q[rob_if.Q1_from_dispatcher].busy
                                            && rob_q[rob_if.Q1_from_dispatcher].ready;
    assign rob_if.if_Q2_rdy_to_dispatcher = id_valid(rob_if.Q2_from_dispatcher)
                                            && rob_q[rob_if.Q2_from_dispatcher].busy
                                            && rob_q[rob_if.Q2_from_dispatcher].ready;
    assign rob_if.data1_to_dispatcher     = id_valid(rob_if.Q1_from_dispatcher)
                                            ? rob_q[rob_if.Q1_from_dispatcher].value : '0;
    assign rob_if.data2_to_dispatcher     = id_valid(rob_if.Q2_from_dispatcher)
                                            ? rob_q[rob_if.Q2_from_dispatcher].value : '0;
    assign rob_if.head_rob_id_to_lsb      = (count_q == '0) ? ROB_RESET : head_q;
    assign rob_if.store_commit_to_lsb     = store_commit_q & rdy_in;
    assign rob_if.enable_to_register      = reg_en_q & rdy_in;
    assign rob_if.reg_id_to_register      = reg_id_q;
    assign rob_if.rob_id_to_register      = reg_rob_q;
    assign rob_if.data_to_register        = reg_data_q;
    assign rob_if.rollback_flag           = rollback_q & rdy_in;
    assign rob_if.rollback_pos_to_fetcher = rollback_pos_q;
    assign rob_if.dbg_head                = head_q;
    assign rob_if.dbg_tail                = tail_q;
    assign rob_if.dbg_count               = count_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer; register commits are scored against a queue
// of expected ROB ids filled at allocation time.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;

    reorder_buffer_if rif ();

    reorder_buffer #(.DEPTH(ROB_DEPTH)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .rob_if (rif)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    logic [ROB_W-1:0] exp_q[$];
    rob_type_t        busy_ids[$];
    reg_type_t        model_rd  [32];
    data_type_t       model_val [32];
    rob_type_t        m_tail;
    rob_type_t        mon_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic alloc(input reg_type_t rd, input logic st, input logic jmp,
                         input logic pred, input addr_type_t rb, input logic accept);
        rif.enable_from_dispatcher            = 1'b1;
        rif.rd_from_dispatcher                = rd;
        rif.is_load_from_dispatcher           = 1'b0;
        rif.is_store_from_dispatcher          = st;
        rif.is_jump_from_dispatcher           = jmp;
        rif.if_jump_predicted_from_dispatcher = pred;
        rif.inst_pos_from_dispatcher          = 32'h1000 + 32'(m_tail) * 4;
        rif.roll_back_pos_from_dispatcher     = rb;
        if (accept) begin
            model_rd[m_tail] = rd;
            if (rd != '0 && !st) exp_q.push_back(m_tail);
            busy_ids.push_back(m_tail);
            m_tail = (m_tail == rob_type_t'(ROB_DEPTH)) ? rob_type_t'(1) : m_tail + 1'b1;
        end
        tick();
        rif.enable_from_dispatcher = 1'b0;
    endtask

    task automatic cdb(input logic alu_en, input rob_type_t alu_id, input data_type_t alu_val,
                       input logic jf, input logic lsu_en, input rob_type_t lsu_id,
                       input data_type_t lsu_val);
        rif.enable_from_alu    = alu_en;
        rif.rob_id_from_rs     = alu_id;
        rif.result_from_alu    = alu_val;
        rif.jump_flag_from_alu = jf;
        rif.enable_from_lsu    = lsu_en;
        rif.rob_id_from_lsb    = lsu_id;
        rif.result_from_lsu    = lsu_val;
        if (alu_en) model_val[alu_id] = alu_val;
        if (lsu_en) model_val[lsu_id] = lsu_val;
        tick();
        rif.enable_from_alu = 1'b0;
        rif.enable_from_lsu = 1'b0;
    endtask

    // Register-write monitor: every commit must match the oldest expected id.
    always begin
        @(posedge clk_in);
        #1;
        if (rif.enable_to_register === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("commit_unexpected", 32'(rif.enable_to_register), 32'd0);
            end else begin
                mon_id = exp_q.pop_front();
                chk("commit_rob_id", 32'(rif.rob_id_to_register), 32'(mon_id));
                chk("commit_reg_id", 32'(rif.reg_id_to_register), 32'(model_rd[mon_id]));
                chk("commit_data", rif.data_to_register, model_val[mon_id]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rob_type_t jid;
        rif.enable_from_dispatcher            = 1'b0;
        rif.rd_from_dispatcher                = '0;
        rif.is_load_from_dispatcher           = 1'b0;
        rif.is_store_from_dispatcher          = 1'b0;
        rif.is_jump_from_dispatcher           = 1'b0;
        rif.if_jump_predicted_from_dispatcher = 1'b0;
        rif.inst_pos_from_dispatcher          = '0;
        rif.roll_back_pos_from_dispatcher     = '0;
        rif.Q1_from_dispatcher                = '0;
        rif.Q2_from_dispatcher                = '0;
        rif.enable_from_alu                   = 1'b0;
        rif.rob_id_from_rs                    = '0;
        rif.result_from_alu                   = '0;
        rif.jump_flag_from_alu                = 1'b0;
        rif.enable_from_lsu                   = 1'b0;
        rif.rob_id_from_lsb                   = '0;
        rif.result_from_lsu                   = '0;
        m_tail = rob_type_t'(1);

        // Reset state
        tick();
        tick();
        chk("rst_rob_id", 32'(rif.rob_id_to_dispatcher), 32'd1);
        chk("rst_full", 32'(rif.full_to_dispatcher), 32'd0);
        chk("rst_head_lsb", 32'(rif.head_rob_id_to_lsb), 32'd0);
        chk("rst_en_reg", 32'(rif.enable_to_register), 32'd0);
        chk("rst_store", 32'(rif.store_commit_to_lsb), 32'd0);
        chk("rst_rollback", 32'(rif.rollback_flag), 32'd0);
        chk("rst_rb_pos", rif.rollback_pos_to_fetcher, 32'd0);
        chk("rst_count", 32'(rif.dbg_count), 32'd0);
        rst_in = 1'b1;
        tick();

        // Single allocate / writeback / commit
        alloc(5'd5, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("t1_count", 32'(rif.dbg_count), 32'd1);
        chk("t1_tail", 32'(rif.rob_id_to_dispatcher), 32'd2);
        chk("t1_head_lsb", 32'(rif.head_rob_id_to_lsb), 32'd1);
        rif.Q1_from_dispatcher = 5'd1;
        #1;
        chk("t1_q1_notready", 32'(rif.if_Q1_rdy_to_dispatcher), 32'd0);
        cdb(1'b1, 5'd1, 32'h1234, 1'b0, 1'b0, '0, '0);
        chk("t1_q1_ready", 32'(rif.if_Q1_rdy_to_dispatcher), 32'd1);
        chk("t1_q1_data", rif.data1_to_dispatcher, 32'h1234);
        chk("t1_no_early_commit", 32'(rif.enable_to_register), 32'd0);
        tick();
        chk("t1_en_reg", 32'(rif.enable_to_register), 32'd1);
        chk("t1_reg_id", 32'(rif.reg_id_to_register), 32'd5);
        chk("t1_data", rif.data_to_register, 32'h1234);
        chk("t1_rob_id", 32'(rif.rob_id_to_register), 32'd1);
        chk("t1_count_back", 32'(rif.dbg_count), 32'd0);
        tick();
        chk("t1_pulse_one_cycle", 32'(rif.enable_to_register), 32'd0);

        // Out-of-order writeback, in-order commit
        alloc(5'd6, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        alloc(5'd7, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        cdb(1'b1, 5'd3, 32'h33, 1'b0, 1'b0, '0, '0);
        chk("t2_blocked_by_head", 32'(rif.enable_to_register), 32'd0);
        cdb(1'b1, 5'd2, 32'h22, 1'b0, 1'b0, '0, '0);
        chk("t2_not_yet", 32'(rif.enable_to_register), 32'd0);
        tick();
        chk("t2_first_en", 32'(rif.enable_to_register), 32'd1);
        chk("t2_first_id", 32'(rif.rob_id_to_register), 32'd2);
        tick();
        chk("t2_second_en", 32'(rif.enable_to_register), 32'd1);
        chk("t2_second_id", 32'(rif.rob_id_to_register), 32'd3);
        tick();
        chk("t2_count", 32'(rif.dbg_count), 32'd0);

        // Operand queries
        alloc(5'd8, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        rif.Q1_from_dispatcher = 5'd4;
        rif.Q2_from_dispatcher = 5'd3;
        #1;
        chk("q_busy_not_ready", 32'(rif.if_Q1_rdy_to_dispatcher), 32'd0);
        chk("q_retired", 32'(rif.if_Q2_rdy_to_dispatcher), 32'd0);
        cdb(1'b0, '0, '0, 1'b0, 1'b1, 5'd4, 32'd7);
        rif.Q2_from_dispatcher = 5'd4;
        #1;
        chk("q1_ready", 32'(rif.if_Q1_rdy_to_dispatcher), 32'd1);
        chk("q1_data", rif.data1_to_dispatcher, 32'd7);
        chk("q2_ready", 32'(rif.if_Q2_rdy_to_dispatcher), 32'd1);
        chk("q2_data", rif.data2_to_dispatcher, 32'd7);
        rif.Q1_from_dispatcher = 5'd0;
        #1;
        chk("q1_id0", 32'(rif.if_Q1_rdy_to_dispatcher), 32'd0);
        tick();
        rif.Q1_from_dispatcher = 5'd4;
        #1;
        chk("q1_after_commit", 32'(rif.if_Q1_rdy_to_dispatcher), 32'd0);

        // Both CDBs in one cycle, then a CDB to a non-busy id
        alloc(5'd9, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        alloc(5'd10, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        cdb(1'b1, 5'd5, 32'hAAAA, 1'b0, 1'b1, 5'd6, 32'hBBBB);
        rif.Q1_from_dispatcher = 5'd5;
        rif.Q2_from_dispatcher = 5'd6;
        #1;
        chk("dual_q1_ready", 32'(rif.if_Q1_rdy_to_dispatcher), 32'd1);
        chk("dual_q1_data", rif.data1_to_dispatcher, 32'hAAAA);
        chk("dual_q2_ready", 32'(rif.if_Q2_rdy_to_dispatcher), 32'd1);
        chk("dual_q2_data", rif.data2_to_dispatcher, 32'hBBBB);
        cdb(1'b1, 5'd12, 32'hDEAD, 1'b0, 1'b0, '0, '0);
        rif.Q1_from_dispatcher = 5'd12;
        #1;
        chk("cdb_nonbusy_ignored", 32'(rif.if_Q1_rdy_to_dispatcher), 32'd0);
        tick();
        tick();
        chk("dual_count", 32'(rif.dbg_count), 32'd0);
        busy_ids.delete();

        // Store commit
        alloc(5'd0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        cdb(1'b0, '0, '0, 1'b0, 1'b1, 5'd7, 32'h99);
        tick();
        chk("store_commit", 32'(rif.store_commit_to_lsb), 32'd1);
        chk("store_no_reg", 32'(rif.enable_to_register), 32'd0);
        tick();
        chk("store_pulse_end", 32'(rif.store_commit_to_lsb), 32'd0);
        busy_ids.delete();

        // Fill, full flag, wrap, drop when completely full
        for (int i = 0; i < 15; i++) begin
            alloc(5'd0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
            chk("fill_tail", 32'(rif.rob_id_to_dispatcher), 32'(m_tail));
        end
        chk("fill_count", 32'(rif.dbg_count), 32'd15);
        chk("fill_full", 32'(rif.full_to_dispatcher), 32'd1);
        chk("fill_wrapped_tail", 32'(rif.rob_id_to_dispatcher), 32'd7);
        jid = busy_ids.pop_front();
        cdb(1'b1, jid, 32'd0, 1'b0, 1'b0, '0, '0);
        tick();
        chk("fill_commit_count", 32'(rif.dbg_count), 32'd14);
        chk("fill_not_full", 32'(rif.full_to_dispatcher), 32'd0);
        alloc(5'd0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        alloc(5'd0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("fill_count16", 32'(rif.dbg_count), 32'd16);
        alloc(5'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("fill_drop_count", 32'(rif.dbg_count), 32'd16);
        chk("fill_drop_tail", 32'(rif.rob_id_to_dispatcher), 32'(m_tail));
        while (busy_ids.size() > 0) begin
            jid = busy_ids.pop_front();
            cdb(1'b1, jid, 32'd0, 1'b0, 1'b0, '0, '0);
        end
        for (int k = 0; k < 20 && rif.dbg_count != '0; k++) tick();
        chk("drain_count", 32'(rif.dbg_count), 32'd0);
        chk("drain_head_lsb", 32'(rif.head_rob_id_to_lsb), 32'd0);

        // Correctly predicted jump: no rollback
        jid = m_tail;
        alloc(5'd0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
        cdb(1'b1, jid, 32'd0, 1'b1, 1'b0, '0, '0);
        tick();
        chk("jump_ok_no_rollback", 32'(rif.rollback_flag), 32'd0);
        chk("jump_ok_count", 32'(rif.dbg_count), 32'd0);
        busy_ids.delete();

        // Mispredicted jump: rollback, flush, same-cycle alloc and CDB dropped
        jid = m_tail;
        alloc(5'd1, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1);
        alloc(5'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        cdb(1'b1, jid, 32'h44, 1'b0, 1'b0, '0, '0);
        rif.enable_from_lsu = 1'b1;
        rif.rob_id_from_lsb = jid + 1'b1;
        rif.result_from_lsu = 32'h55;
        alloc(5'd3, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        rif.enable_from_lsu = 1'b0;
        chk("rb_flag", 32'(rif.rollback_flag), 32'd1);
        chk("rb_pos", rif.rollback_pos_to_fetcher, 32'h100);
        chk("rb_link_write", 32'(rif.enable_to_register), 32'd1);
        chk("rb_count", 32'(rif.dbg_count), 32'd0);
        chk("rb_head", 32'(rif.dbg_head), 32'd1);
        chk("rb_tail", 32'(rif.dbg_tail), 32'd1);
        chk("rb_rob_id", 32'(rif.rob_id_to_dispatcher), 32'd1);
        rif.Q1_from_dispatcher = jid + 1'b1;
        #1;
        chk("rb_cdb_discarded", 32'(rif.if_Q1_rdy_to_dispatcher), 32'd0);
        m_tail = rob_type_t'(1);
        busy_ids.delete();
        tick();
        chk("rb_pulse_end", 32'(rif.rollback_flag), 32'd0);

        // Global stall ignores allocation
        rdy_in = 1'b0;
        alloc(5'd0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        chk("stall_count", 32'(rif.dbg_count), 32'd0);
        chk("stall_tail", 32'(rif.rob_id_to_dispatcher), 32'd1);
        rdy_in = 1'b1;

        // Asynchronous reset in mid-operation
        alloc(5'd0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        alloc(5'd0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("pre_reset_count", 32'(rif.dbg_count), 32'd2);
        #2;
        rst_in = 1'b0;
        #1;
        chk("async_rst_tail", 32'(rif.rob_id_to_dispatcher), 32'd1);
        chk("async_rst_count", 32'(rif.dbg_count), 32'd0);
        chk("async_rst_head_lsb", 32'(rif.head_rob_id_to_lsb), 32'd0);
        rst_in = 1'b1;
        m_tail = rob_type_t'(1);
        busy_ids.delete();
        tick();
        chk("post_rst_tail", 32'(rif.rob_id_to_dispatcher), 32'd1);

        alloc(5'd12, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        cdb(1'b1, 5'd1, 32'h77, 1'b0, 1'b0, '0, '0);
        tick();
        chk("post_rst_commit", 32'(rif.enable_to_register), 32'd1);
        tick();
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order commit buffer. It is the receiving end of the dispatcher's ROB issue interface.
- Allocates a ROB id per dispatched instruction.
- Answers operand-readiness queries (Q1/Q2) combinationally.
- Captures ALU/LSU CDB results and retires one instruction per cycle to the register file or LSB.
- Detects branch mispredictions at commit and broadcasts rollback to the whole core.

Parameters:
- DEPTH, 16, number of entries. ROB ids run 1..DEPTH; id 0 is ROB_RESET, meaning "no producer".
- ROB_W, 5, width of ROB_TYPE. Must satisfy 2^ROB_W > DEPTH.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global stall; low freezes all state.
- enable_from_dispatcher  in  1  allocate one entry this cycle.
- rd_from_dispatcher  in  5  destination register (0 = none).
- is_load_from_dispatcher / is_store_from_dispatcher / is_jump_from_dispatcher  in  1 each  instruction class.
- if_jump_predicted_from_dispatcher  in  1  fetcher's taken prediction.
- inst_pos_from_dispatcher  in  32  instruction PC.
- roll_back_pos_from_dispatcher  in  32  PC to refetch on mispredict.
- rob_id_to_dispatcher  out  ROB_W  id the next allocation will receive (current tail).
- full_to_dispatcher  out  1  no allocation may be issued.
- Q1_from_dispatcher, Q2_from_dispatcher  in  ROB_W  queried producer ids.
- if_Q1_rdy_to_dispatcher, if_Q2_rdy_to_dispatcher  out  1  queried entry holds its result.
- data1_to_dispatcher, data2_to_dispatcher  out  32  that result.
- enable_from_alu  in  1  ALU CDB valid.
- rob_id_from_rs  in  ROB_W  ALU CDB id.
- result_from_alu  in  32  ALU CDB data.
- jump_flag_from_alu  in  1  actual branch outcome.
- enable_from_lsu  in  1  LSU CDB valid.
- rob_id_from_lsb  in  ROB_W  LSU CDB id.
- result_from_lsu  in  32  LSU CDB data.
- head_rob_id_to_lsb  out  ROB_W  id at head (ROB_RESET when empty).
- store_commit_to_lsb  out  1  pulse: head store retired.
- enable_to_register  out  1  pulse: write committed value.
- reg_id_to_register  out  5  committed rd.
- rob_id_to_register  out  ROB_W  committed id; register file clears its tag only on match.
- data_to_register  out  32  committed value.
- rollback_flag  out  1  pulse: mispredict flush.
- rollback_pos_to_fetcher  out  32  redirect PC.

Behaviour:
- Per-entry state: busy, ready, rd, value, is_load, is_store, is_jump, pred, real, inst_pos, rb_pos.
- Pointers head and tail run over 1..DEPTH and wrap DEPTH→1. Counter count runs 0..DEPTH.
- Reset (async, rst_in=0):
  - head=tail=1, count=0, all busy=0.
  - All registered outputs 0; rollback_pos_to_fetcher=0.
- full_to_dispatcher = (count >= DEPTH-1). This leaves one slot of slack for the dispatcher's registered issue.
- Allocate (posedge, enable_from_dispatcher=1):
  - Write the entry at tail with busy=1, ready=0; tail advances.
  - Allocation when count==DEPTH is dropped.
- Writeback (posedge): for each valid CDB whose id names a busy entry, set ready=1 and value=result.
  - ALU writeback also sets real=jump_flag_from_alu.
  - Both CDBs with distinct ids apply in the same cycle.
  - A CDB to a non-busy id or to id 0 is ignored.
  - A store becomes ready through the LSU CDB; the data is ignored.
- Query (combinational): if_Qx_rdy = (Qx!=0) && busy[Qx] && ready[Qx]; datax = value[Qx].
- Commit (posedge, at most one per cycle, when count>0 and head ready):
  - Clear busy at head; head advances.
  - If rd!=0 and not a store: pulse enable_to_register with reg_id, data and rob_id.
  - If store: pulse store_commit_to_lsb.
  - If is_jump and pred!=real: also pulse rollback_flag with rollback_pos_to_fetcher=rb_pos, then flush.
- Flush (same edge): all busy=0; head=tail=1, count=0.
  - Any allocation or CDB write in that cycle is discarded.
  - The register write of the mispredicting jump (JAL/JALR rd) still happens.
- Latency:
  - A result written at edge t is visible to queries after t.
  - The earliest commit of that entry is edge t+1.
- Count:
  - Allocate + commit in the same cycle: count unchanged.
  - Allocate only: +1. Commit only: −1.
- Pulse outputs (enable_to_register, store_commit_to_lsb, rollback_flag) last exactly one cycle. They are forced 0 in any cycle with rdy_in=0.
- rdy_in=0: pointers, entries and count hold; allocations and CDB writes are ignored.

Decomposition:
- Shared constants file holds: ROB_TYPE, ROB_RESET(=0), DATA_TYPE, ADDR_TYPE, REG_TYPE, TRUE/FALSE.
- Pointer-increment-with-wrap is a local function.
- No sub-module; the block is a single module.

Test Plan:
- Allocate rd=5 (id 1) → ALU CDB id1 value 0x1234 → one cycle later: enable_to_register=1, reg_id=5, data=0x1234, rob_id=1; count returns to 0.
- Allocate ids 1,2; CDB id2 first, then id1 → commits occur in order 1 then 2, on consecutive cycles.
- Query Q1=3 while id3 busy and not ready → rdy=0. After CDB id3 value 7 → rdy=1, data=7. Q1=0 → rdy=0.
- Fill 15 entries → full_to_dispatcher=1. Commit one → full=0. Then allocate past index 16 and check the tail wraps to 1.
- Branch with pred=1, ALU real=0, rb_pos=0x100 → at commit: rollback_flag=1, rollback_pos_to_fetcher=0x100; next cycle count=0 and head=tail=1. A same-cycle allocation is dropped.
- Drive rst_in low mid-operation with entries busy → outputs clear immediately; after release, rob_id_to_dispatcher=1.
